// File: rtl/pll_profile_reconfig.sv
// pll_profile_reconfig: writes the NTSC/PAL write list to the PLL reconfig IP and waits for the PLL to relock
module pll_profile_reconfig #(
  parameter logic [31:0] M_WORD       = 32'h0000_0404,
  parameter logic [31:0] K_NTSC       = 32'd425936216,
  parameter logic [31:0] K_PAL        = 32'd108653223,
  parameter logic [31:0] C0_WORD      = 32'h0002_0403,
  parameter logic [31:0] C1_WORD      = 32'h0004_0e0e,
  parameter logic [31:0] C2_WORD      = 32'h0008_1c1c,
  parameter logic [31:0] C3_WORD      = 32'h000c_1c1c,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd7_425_000
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        start,
  input  logic        profile,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        active_profile,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);
  typedef enum logic [1:0] {IDLE, WR, GAP, LOCKWAIT} state_t;
  state_t state;
  logic [3:0] idx, sel_idx;
  logic prof_q, seen_low, lock_m, lock_s;
  logic [23:0] timer;
  logic [5:0] nxt_addr;
  logic [31:0] nxt_data;
  always_comb begin
    sel_idx = (state == IDLE) ? 4'd0 : idx;
    nxt_addr = (sel_idx == 4'd1) ? 6'd4 :
               (sel_idx == 4'd2) ? 6'd7 :
               (sel_idx == 4'd7) ? 6'd2 :
               (sel_idx >= 4'd3 && sel_idx <= 4'd6) ? 6'd5 : 6'd0;
    nxt_data = (sel_idx == 4'd1) ? M_WORD :
               (sel_idx == 4'd2) ? (prof_q ? K_PAL : K_NTSC) :
               (sel_idx == 4'd3) ? C0_WORD :
               (sel_idx == 4'd4) ? C1_WORD :
               (sel_idx == 4'd5) ? C2_WORD :
               (sel_idx == 4'd6) ? C3_WORD :
               (sel_idx == 4'd8) ? 32'd1 : 32'd0;
  end
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= 4'd0;
      prof_q <= 1'b0;
      seen_low <= 1'b0;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      timer <= 24'd0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      active_profile <= 1'b0;
      mgmt_write <= 1'b0;
      mgmt_address <= 6'd0;
      mgmt_writedata <= 32'd0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          error <= 1'b0;
          prof_q <= profile;
          idx <= 4'd0;
          mgmt_write <= 1'b1;
          mgmt_address <= nxt_addr;
          mgmt_writedata <= nxt_data;
          state <= WR;
        end
        WR: if (!mgmt_waitrequest) begin
          mgmt_write <= 1'b0;
          idx <= idx + 4'd1;
          state <= GAP;
        end
        GAP: if (idx < 4'd9) begin
          mgmt_write <= 1'b1;
          mgmt_address <= nxt_addr;
          mgmt_writedata <= nxt_data;
          state <= WR;
        end else begin
          timer <= 24'd0;
          seen_low <= 1'b0;
          state <= LOCKWAIT;
        end
        LOCKWAIT: begin
          timer <= (&timer) ? timer : timer + 24'd1;
          seen_low <= seen_low | ~lock_s;
          if (lock_s && (seen_low || timer >= 24'd16)) begin
            active_profile <= prof_q;
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else if (timer >= LOCK_TIMEOUT) begin
            error <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
